// File: rtl/cpu_bus_bridge.sv
// Bridges the core's instruction and data ports onto one valid/ready memory bus
// and single-steps the core through o_cpu_ce, one pulse per completed fetch/data step.
module cpu_bus_bridge #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ce,
   output logic        o_cpu_ce,
   input  logic [31:0] i_addr_i,
   output logic [31:0] o_data_i,
   input  logic [31:0] i_addr_d,
   input  logic [31:0] i_data_wr_d,
   input  logic [3:0]  i_wr_d,
   input  logic        i_rd_d,
   output logic [31:0] o_data_rd_d,
   output logic        o_bus_valid,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wr_data,
   output logic [3:0]  o_bus_we,
   input  logic        i_bus_ready,
   input  logic [31:0] i_bus_rd_data,
   output logic        o_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DATA  = 2'd2,
      S_STEP  = 2'd3
   } state_t;

   localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT);

   state_t      state_q, state_d;
   logic        cpu_ce_q, cpu_ce_d;
   logic        bus_valid_q, bus_valid_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wr_data_q, bus_wr_data_d;
   logic [3:0]  bus_we_q, bus_we_d;
   logic        err_q, err_d;
   logic [31:0] data_i_q, data_i_d;
   logic [31:0] data_rd_d_q, data_rd_d_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        tmo_hit;
   logic        has_data;

   // Abort fires in the wait cycle that brings the count up to the limit.
   assign tmo_hit  = (TMO_LIMIT != 17'd0) && (({1'b0, tmo_cnt_q} + 17'd1) >= TMO_LIMIT);
   assign has_data = i_rd_d || (i_wr_d != 4'd0);

   // Next-state and next-output logic; ready always takes priority over the timeout.
   always_comb begin
      state_d       = state_q;
      cpu_ce_d      = 1'b0;
      bus_valid_d   = bus_valid_q;
      bus_addr_d    = bus_addr_q;
      bus_wr_data_d = bus_wr_data_q;
      bus_we_d      = bus_we_q;
      err_d         = 1'b0;
      data_i_d      = data_i_q;
      data_rd_d_d   = data_rd_d_q;
      tmo_cnt_d     = tmo_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (i_ce) begin
               bus_addr_d  = i_addr_i;
               bus_we_d    = 4'd0;
               bus_valid_d = 1'b1;
               tmo_cnt_d   = 16'd0;
               state_d     = S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            if (i_bus_ready) begin
               data_i_d = i_bus_rd_data;
               if (has_data) begin
                  bus_addr_d    = i_addr_d;
                  bus_wr_data_d = i_data_wr_d;
                  bus_we_d      = i_wr_d;
                  bus_valid_d   = 1'b1;
                  tmo_cnt_d     = 16'd0;
                  state_d       = S_DATA;
               end else begin
                  bus_valid_d = 1'b0;
                  cpu_ce_d    = 1'b1;
                  state_d     = S_STEP;
               end
            end else if (tmo_hit) begin
               data_i_d    = NOP_INSN;
               bus_valid_d = 1'b0;
               err_d       = 1'b1;
               cpu_ce_d    = 1'b1;
               state_d     = S_STEP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         S_DATA: begin
            if (i_bus_ready) begin
               if (bus_we_q == 4'd0) begin
                  data_rd_d_d = i_bus_rd_data;
               end else begin
                  data_rd_d_d = data_rd_d_q;
               end
               bus_valid_d = 1'b0;
               bus_we_d    = 4'd0;
               cpu_ce_d    = 1'b1;
               state_d     = S_STEP;
            end else if (tmo_hit) begin
               // An aborted read reports zero; an aborted write is just dropped.
               if (bus_we_q == 4'd0) begin
                  data_rd_d_d = 32'd0;
               end else begin
                  data_rd_d_d = data_rd_d_q;
               end
               bus_valid_d = 1'b0;
               bus_we_d    = 4'd0;
               err_d       = 1'b1;
               cpu_ce_d    = 1'b1;
               state_d     = S_STEP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         S_STEP: begin
            state_d = S_IDLE;
         end
         default: begin
            bus_valid_d = 1'b0;
            bus_we_d    = 4'd0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q       <= S_IDLE;
         cpu_ce_q      <= 1'b0;
         bus_valid_q   <= 1'b0;
         bus_addr_q    <= 32'd0;
         bus_wr_data_q <= 32'd0;
         bus_we_q      <= 4'd0;
         err_q         <= 1'b0;
         data_i_q      <= NOP_INSN;
         data_rd_d_q   <= 32'd0;
         tmo_cnt_q     <= 16'd0;
      end else begin
         state_q       <= state_d;
         cpu_ce_q      <= cpu_ce_d;
         bus_valid_q   <= bus_valid_d;
         bus_addr_q    <= bus_addr_d;
         bus_wr_data_q <= bus_wr_data_d;
         bus_we_q      <= bus_we_d;
         err_q         <= err_d;
         data_i_q      <= data_i_d;
         data_rd_d_q   <= data_rd_d_d;
         tmo_cnt_q     <= tmo_cnt_d;
      end
   end

   assign o_cpu_ce      = cpu_ce_q;
   assign o_bus_valid   = bus_valid_q;
   assign o_bus_addr    = bus_addr_q;
   assign o_bus_wr_data = bus_wr_data_q;
   assign o_bus_we      = bus_we_q;
   assign o_err         = err_q;
   assign o_data_i      = data_i_q;
   assign o_data_rd_d   = data_rd_d_q;

endmodule

// File: doc/cpu_bus_bridge.md
Name: cpu_bus_bridge

Overview:
- Sits between the cpu core and system memory. It merges the core's separate instruction and data ports onto one shared valid/ready memory bus.
- It advances the core by driving the core's clock enable, one pulse per completed step.
- Each step performs one instruction fetch, then the optional data access, latches the results, and then releases the core for exactly one cycle.
- A bus timeout keeps the core from hanging on an unresponsive slave.

Parameters:
- TIMEOUT, 255, max cycles to wait for i_bus_ready per transaction; 0 disables the timeout; legal range 0..65535.
- NOP_INSN, 32'h00000013, value returned as instruction after reset or after a fetch timeout.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_ce  in  1  global run enable.
- o_cpu_ce  out  1  clock enable to core.
- i_addr_i  in  32  core instruction address.
- o_data_i  out  32  latched instruction to core.
- i_addr_d  in  32  core data address.
- i_data_wr_d  in  32  core write data.
- i_wr_d  in  4  core byte write enables.
- i_rd_d  in  1  core read request.
- o_data_rd_d  out  32  latched read data to core.
- o_bus_valid  out  1  bus request valid.
- o_bus_addr  out  32  bus address.
- o_bus_wr_data  out  32  bus write data.
- o_bus_we  out  4  bus byte write enables; 0 means read.
- i_bus_ready  in  1  slave accepts/completes the request this cycle.
- i_bus_rd_data  in  32  read data, valid in the cycle i_bus_ready=1.
- o_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset is asynchronous, active-high, one clock (i_clk, i_rst).
- Reset values:
  - state=IDLE.
  - o_cpu_ce=0, o_bus_valid=0, o_bus_addr=0, o_bus_wr_data=0, o_bus_we=0, o_err=0.
  - o_data_i=NOP_INSN, o_data_rd_d=0, timeout counter=0.
- States: IDLE, FETCH, DATA, STEP.
- IDLE:
  - If i_ce=1, capture i_addr_i into o_bus_addr, set o_bus_we=0, set o_bus_valid=1, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: hold o_bus_valid and address stable until i_bus_ready=1. On ready:
  - Latch i_bus_rd_data into o_data_i.
  - If i_rd_d=1 or i_wr_d!=0: capture i_addr_d, i_data_wr_d and i_wr_d onto the bus (o_bus_we=i_wr_d), keep o_bus_valid=1, go to DATA.
  - Otherwise drop o_bus_valid and go to STEP.
- DATA: hold the request until i_bus_ready=1.
  - If o_bus_we==0, latch i_bus_rd_data into o_data_rd_d; for writes, o_data_rd_d keeps its previous value.
  - Drop o_bus_valid, clear o_bus_we, go to STEP.
- STEP:
  - o_cpu_ce=1 for exactly this cycle; o_cpu_ce=0 in all other states.
  - Next state is IDLE.
  - o_data_i and o_data_rd_d remain stable through STEP and until the next latch.
- Core-side inputs are sampled only at the IDLE->FETCH and FETCH->DATA transitions. They are stable because the core is stalled while o_cpu_ce=0.
- Bus rules:
  - o_bus_valid is never deasserted, and address/data/we never change, before the ready cycle.
  - A transaction completes in the same cycle that ready and valid are both high.
  - i_bus_ready while o_bus_valid=0 is ignored.
- Timeout (TIMEOUT>0):
  - The 16-bit counter clears on every new request and increments each cycle in FETCH/DATA while ready=0.
  - When the count reaches TIMEOUT with ready still 0, abort the request: o_bus_valid=0, o_err=1 for one cycle, go to STEP.
  - A fetch abort returns o_data_i=NOP_INSN and skips the data access.
  - A data read abort returns o_data_rd_d=0; a data write abort is simply dropped.
  - If ready arrives in the same cycle the limit is reached, ready wins: normal completion, no o_err.
- i_ce=0 only blocks leaving IDLE. An in-flight transaction and its STEP pulse always complete.
- Minimum step latency with ready tied high:
  - 3 cycles with no data access (IDLE, FETCH, STEP).
  - 4 cycles with a data access (IDLE, FETCH, DATA, STEP).
- Reset asserted mid-transaction returns to reset values immediately. o_bus_valid drops asynchronously and no STEP pulse is issued.

Test Plan:
- Reset then ready tied 1, i_ce=1, i_addr_i=0x100, bus returns 0x00500093 (no data access) -> o_bus_valid with addr 0x100 one cycle, o_data_i=0x00500093, o_cpu_ce pulses once every 3 cycles.
- Fetch then read: i_rd_d=1, i_addr_d=0x2004, slave returns 0xDEADBEEF after 2 wait cycles -> DATA request holds addr 0x2004, we=0 for 3 cycles, o_data_rd_d=0xDEADBEEF, single o_cpu_ce pulse.
- Write: i_wr_d=4'b0011, i_addr_d=0x3000, i_data_wr_d=0x0000ABCD -> bus shows addr 0x3000, we=0011, data 0x0000ABCD stable until ready, o_data_rd_d unchanged.
- Timeout: TIMEOUT=4, slave never ready on fetch -> after 4 cycles valid drops, o_err=1 one cycle, o_data_i=0x00000013, one o_cpu_ce pulse, no DATA request.
- Ready on limit cycle: TIMEOUT=4, ready arrives in the 4th wait cycle with 0x12345678 -> o_data_i=0x12345678, o_err stays 0.
- Reset asserted during DATA wait, and i_ce=0 after a step -> valid drops immediately with no o_cpu_ce and o_data_i=NOP_INSN; with i_ce=0 the FSM stays in IDLE, no bus activity.
